// File: rtl/addsub_dispatcher.sv
// -----------------------------------------------------------------------------
// addsub_dispatcher
//
// Command-queue front end for a multi-cycle add/subtract core. Requests from a
// valid/ready producer are buffered in a small FIFO and issued one at a time to
// the core. Each issue is a one-cycle start pulse. The operands stay registered
// until the next issue. The core's sum/carry are captured into a result
// register, which is offered to a valid/ready consumer. No arithmetic happens
// here.
//
// Parameters
//   N        operand/result width (must match the core)
//   DEPTH    command FIFO depth, power of 2, >= 2
//   TIMEOUT  cycles to wait for core_done after WAIT entry, >= 2
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   in_valid/in_ready            producer handshake
//   in_a, in_b, in_sub           command: operands and op select (1 = subtract)
//   core_a, core_b, core_addsub  registered operands/op select to the core
//   core_start                   one-cycle issue pulse
//   core_sum, core_cout          core result
//   core_done                    core completion strobe
//   core_calculating             core busy status (observed only)
//   res_valid/res_ready          consumer handshake
//   res_sum, res_cout, res_sub   captured result and its op-select tag
//   fifo_count                   queued commands, including the one in flight
//   busy                         FSM is in ISSUE or WAIT
//   timeout_err                  sticky core-timeout flag, cleared only by rst
// -----------------------------------------------------------------------------
module addsub_dispatcher #(
   parameter int N       = 8,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [N-1:0]             in_a,
   input  logic [N-1:0]             in_b,
   input  logic                     in_sub,
   output logic [N-1:0]             core_a,
   output logic [N-1:0]             core_b,
   output logic                     core_addsub,
   output logic                     core_start,
   input  logic [N-1:0]             core_sum,
   input  logic                     core_cout,
   input  logic                     core_done,
   input  logic                     core_calculating,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [N-1:0]             res_sum,
   output logic                     res_cout,
   output logic                     res_sub,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     busy,
   output logic                     timeout_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   // The counter reaches TIMEOUT on the edge where it leaves this value.
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT
   } state_t;

   typedef struct packed {
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic         sub;
   } cmd_t;

   cmd_t          mem [DEPTH];
   cmd_t          head;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   state_t        state;
   state_t        state_nxt;
   logic [TW-1:0] tmo_cnt;

   logic push;
   logic pop;
   logic load;
   logic tmo_hit;
   logic in_wait;

   // Busy status from the core is informational; control never depends on it.
   logic unused_status;
   assign unused_status = core_calculating;

   // ---------------------------------------------------------------------------
   // Handshake and control decodes
   // ---------------------------------------------------------------------------
   // No bypass: a full FIFO refuses a push even when a pop happens on the same edge.
   assign in_ready = (count < DEPTH_C) & ~rst;
   assign push     = in_valid & in_ready;
   assign in_wait  = (state == S_WAIT);
   assign tmo_hit  = (tmo_cnt == TMO_LAST);
   assign pop      = in_wait & (core_done | tmo_hit);
   // Wait for the result register to drain before issuing; one command in flight.
   assign load     = (state == S_IDLE) & (count != '0) & ~res_valid;
   assign head     = mem[rd_ptr];

   assign fifo_count = count;

   // ---------------------------------------------------------------------------
   // Command FIFO
   // ---------------------------------------------------------------------------
   // NOTE: storage is deliberately left out of reset; the pointers and count
   // alone define which entries are valid, so a flush only needs those.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= '{a: in_a, b: in_b, sub: in_sub};
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement or process order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // Pointers are PW bits wide, so they wrap modulo DEPTH on their own.
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: state register / next-state / outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // NOTE: the default assignment at the top keeps every path assigned, so no
   // latch is inferred for state_nxt.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (load) state_nxt = S_ISSUE;
         S_ISSUE: state_nxt = S_WAIT;
         S_WAIT:  if (core_done || tmo_hit) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      core_start = (state == S_ISSUE);
      busy       = (state != S_IDLE);
   end

   // ---------------------------------------------------------------------------
   // Timeout counter: cleared in ISSUE, counts every WAIT cycle
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt <= '0;
      end else if (state == S_ISSUE) begin
         tmo_cnt <= '0;
      end else if (in_wait) begin
         tmo_cnt <= tmo_cnt + TW'(1);
      end
   end

   // ---------------------------------------------------------------------------
   // Operand registers: loaded on IDLE->ISSUE, held until the next load
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         core_a      <= '0;
         core_b      <= '0;
         core_addsub <= 1'b0;
      end else if (load) begin
         core_a      <= head.a;
         core_b      <= head.b;
         core_addsub <= head.sub;
      end
   end

   // ---------------------------------------------------------------------------
   // Result register and sticky timeout flag
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_valid   <= 1'b0;
         res_sum     <= '0;
         res_cout    <= 1'b0;
         res_sub     <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         // A capture only happens while res_valid is low, because issue waits
         // for the result register to be empty. Capture still takes priority.
         if (in_wait && core_done) begin
            res_valid <= 1'b1;
            res_sum   <= core_sum;
            res_cout  <= core_cout;
            res_sub   <= core_addsub;
         end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
         end
         // If done and the timeout land on the same edge, done wins.
         if (in_wait && !core_done && tmo_hit) begin
            timeout_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_addsub_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_addsub_dispatcher
//
// Scoreboard bench for addsub_dispatcher. A behavioural core model answers each
// core_start after a programmable latency. It can also be stubbed so that it
// never raises done. Each command's hand-computed result is queued when the
// command is issued. A monitor pops and compares on every result handshake.
// -----------------------------------------------------------------------------
module tb_addsub_dispatcher;

   localparam int N       = 8;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 64;
   localparam int CW      = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [N-1:0] sum;
      logic         cout;
      logic         sub;
   } res_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  in_a;
   logic [N-1:0]  in_b;
   logic          in_sub;
   logic [N-1:0]  core_a;
   logic [N-1:0]  core_b;
   logic          core_addsub;
   logic          core_start;
   logic [N-1:0]  core_sum;
   logic          core_cout;
   logic          core_done;
   logic          core_calculating;
   logic          res_valid;
   logic          res_ready;
   logic [N-1:0]  res_sum;
   logic          res_cout;
   logic          res_sub;
   logic [CW-1:0] fifo_count;
   logic          busy;
   logic          timeout_err;

   res_t exp_q[$];
   res_t mon_exp;
   int   checks = 0;
   int   errors = 0;
   int   starts = 0;
   bit   stub     = 1'b0;
   int   core_lat = 2;

   always #5 clk = ~clk;

   addsub_dispatcher #(.N(N), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk              (clk),
      .rst              (rst),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_a             (in_a),
      .in_b             (in_b),
      .in_sub           (in_sub),
      .core_a           (core_a),
      .core_b           (core_b),
      .core_addsub      (core_addsub),
      .core_start       (core_start),
      .core_sum         (core_sum),
      .core_cout        (core_cout),
      .core_done        (core_done),
      .core_calculating (core_calculating),
      .res_valid        (res_valid),
      .res_ready        (res_ready),
      .res_sum          (res_sum),
      .res_cout         (res_cout),
      .res_sub          (res_sub),
      .fifo_count       (fifo_count),
      .busy             (busy),
      .timeout_err      (timeout_err)
   );

   // ---------------------------------------------------------------------------
   // Behavioural core: done pulses core_lat edges after start is sampled
   // ---------------------------------------------------------------------------
   logic     m_busy;
   int       m_cnt;
   logic [N:0] m_r;

   always_comb begin
      m_r = core_addsub ? ({1'b0, core_a} + {1'b0, ~core_b} + 9'd1)
                        : ({1'b0, core_a} + {1'b0, core_b});
   end

   assign core_calculating = m_busy;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy    <= 1'b0;
         m_cnt     <= 0;
         core_done <= 1'b0;
         core_sum  <= '0;
         core_cout <= 1'b0;
      end else begin
         core_done <= 1'b0;
         if (core_start) begin
            m_busy <= 1'b1;
            m_cnt  <= core_lat;
         end else if (m_busy) begin
            if (m_cnt <= 1) begin
               m_busy <= 1'b0;
               if (!stub) begin
                  core_done <= 1'b1;
                  core_sum  <= m_r[N-1:0];
                  core_cout <= m_r[N];
               end
            end else begin
               m_cnt <= m_cnt - 1;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Checking helpers
   // ---------------------------------------------------------------------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: counts start pulses and scores every accepted result.
   always @(negedge clk) begin
      if (!rst) begin
         if (core_start) starts++;
         if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_result", {res_sum, res_cout, res_sub}, 32'hFFFF_FFFF);
            end else begin
               mon_exp = exp_q.pop_front();
               check("result", {res_sum, res_cout, res_sub}, mon_exp);
            end
         end
      end
   end

   // Entered and left at posedge+1. Queues the expected result when has_res is set.
   task automatic push(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub,
                       input bit has_res, input logic [N-1:0] es, input logic ec);
      int n;
      in_a     = a;
      in_b     = b;
      in_sub   = sub;
      in_valid = 1'b1;
      if (has_res) exp_q.push_back('{sum: es, cout: ec, sub: sub});
      for (n = 0; n < 100; n++) begin
         @(negedge clk);
         if (in_ready) break;
      end
      check("push_ready", in_ready, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (fifo_count == 0 && !busy && !res_valid) break;
      end
      check(name, {fifo_count, busy, res_valid}, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_core"}, {core_a, core_b, core_addsub, core_start, in_ready, busy}, 0);
      check({tag, "_res"}, {res_valid, res_sum, res_cout, res_sub, fifo_count, timeout_err}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------------
   // Directed stimulus
   // ---------------------------------------------------------------------------
   initial begin
      int s0;
      int n;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_sub    = 1'b0;
      res_ready = 1'b0;

      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_reset", in_ready, 1);
      @(posedge clk);
      #1;

      // Add: 42 + 15 = 57
      res_ready = 1'b1;
      s0 = starts;
      push(8'd42, 8'd15, 1'b0, 1, 8'd57, 1'b0);
      wait_idle("add_idle");
      check("add_one_start", starts - s0, 1);

      // Subtract to a negative value, then an add that carries out.
      push(8'd2, 8'd4, 1'b1, 1, 8'hFE, 1'b0);
      push(8'd255, 8'd1, 1'b0, 1, 8'h00, 1'b1);
      wait_idle("sub_idle");

      // Fill with the consumer stalled.
      res_ready = 1'b0;
      s0 = starts;
      push(8'd10,  8'd20,  1'b0, 1, 8'd30, 1'b0);
      push(8'd88,  8'd22,  1'b1, 1, 8'd66, 1'b1);
      push(8'd17,  8'd17,  1'b1, 1, 8'd0,  1'b1);
      push(8'd200, 8'd100, 1'b0, 1, 8'd44, 1'b1);
      in_a = 8'd3; in_b = 8'd5; in_sub = 1'b1; in_valid = 1'b1;
      exp_q.push_back('{sum: 8'hFE, cout: 1'b0, sub: 1'b1});
      @(negedge clk);
      check("full_in_ready", in_ready, 0);
      check("full_count", fifo_count, 4);
      for (n = 0; n < 100; n++) begin
         if (res_valid) break;
         @(negedge clk);
      end
      check("bp_res_valid", res_valid, 1);
      check("bp_count_after_pop", fifo_count, 3);
      check("bp_first_sum", res_sum, 30);
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (12) @(negedge clk);
      check("bp_no_start", starts - s0, 1);
      check("bp_hold", {res_valid, res_sum, res_cout, res_sub}, {1'b1, 8'd30, 1'b0, 1'b0});
      check("bp_count_full", fifo_count, 4);
      @(posedge clk);
      #1 res_ready = 1'b1;
      wait_idle("bp_drain");
      check("bp_starts", starts - s0, 5);

      // Timeout with a core that never answers.
      stub = 1'b1;
      push(8'd9, 8'd9, 1'b0, 0, 8'd0, 1'b0);
      for (n = 0; n < 10; n++) begin
         @(negedge clk);
         if (core_start) break;
      end
      check("tmo_start_seen", core_start, 1);
      @(posedge clk);               // WAIT entry edge
      n = 0;
      for (int i = 0; i < TIMEOUT + 10; i++) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (timeout_err) break;
      end
      check("tmo_cycles", n, TIMEOUT);
      check("tmo_flag", timeout_err, 1);
      check("tmo_state", {fifo_count, res_valid, busy}, 0);
      stub = 1'b0;
      @(posedge clk);
      #1;

      // Reset while a command is in WAIT and two more are queued.
      core_lat = 20;
      push(8'd1, 8'd1, 1'b0, 0, 8'd0, 1'b0);
      push(8'd2, 8'd2, 1'b0, 0, 8'd0, 1'b0);
      push(8'd3, 8'd3, 1'b0, 0, 8'd0, 1'b0);
      for (n = 0; n < 20; n++) begin
         @(negedge clk);
         if (busy && !core_start) break;
      end
      check("mid_wait_count", fifo_count, 3);
      #2 rst = 1'b1;
      #1 check_all_zero("async_reset");
      @(negedge clk);
      rst = 1'b0;
      core_lat = 2;
      @(negedge clk);
      check("post_reset", {fifo_count, busy, in_ready}, 1);
      @(posedge clk);
      #1;
      push(8'd24, 8'd64, 1'b0, 1, 8'd88, 1'b0);
      wait_idle("post_reset_idle");

      // Push on the same edge that the head pops.
      push(8'd100, 8'd50, 1'b1, 1, 8'd50, 1'b1);
      for (n = 0; n < 20; n++) begin
         @(negedge clk);
         if (core_done) break;
      end
      check("simul_done_seen", core_done, 1);
      check("simul_count_before", fifo_count, 1);
      in_a = 8'd7; in_b = 8'd8; in_sub = 1'b0; in_valid = 1'b1;
      exp_q.push_back('{sum: 8'd15, cout: 1'b0, sub: 1'b0});
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      check("simul_count_after", fifo_count, 1);
      wait_idle("simul_idle");

      check("scoreboard_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/addsub_dispatcher.md
# addsub_dispatcher

Command-queue front end for the multi-cycle `AdderSubtractor` core.
- Buffers add/subtract requests from a valid/ready producer in a small FIFO.
- Issues each request to the core with a one-cycle `start` pulse and holds the operands stable until `done`.
- Captures `sum`/`cout` into a result register and presents it to a downstream valid/ready consumer.
- Sits directly upstream of the core and also owns its result path; the core is a separate instance wired to the `core_*` ports.

## Interface
- `N`, 8: operand/result width; must equal the core's width parameter.
- `DEPTH`, 4: command FIFO depth; power of 2, ≥2.
- `TIMEOUT`, 64: maximum cycles to wait for `core_done` after `core_start`; ≥2.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset; shared with the core.
- `in_valid`  in  1  producer has a command.
- `in_ready`  out  1  equals `(count < DEPTH) & !rst`.
- `in_a`, `in_b`  in  N  operands.
- `in_sub`  in  1  0 = add, 1 = subtract.
- `core_a`, `core_b`  out  N  registered operands to the core.
- `core_addsub`  out  1  registered op select to the core.
- `core_start`  out  1  one-cycle start pulse.
- `core_sum`  in  N  core result.
- `core_cout`  in  1  core carry-out.
- `core_done`  in  1  core completion strobe.
- `core_calculating`  in  1  core busy; status only, never gates control.
- `res_valid`  out  1  result register full.
- `res_ready`  in  1  consumer accepts the result.
- `res_sum`  out  N  captured sum.
- `res_cout`  out  1  captured carry-out.
- `res_sub`  out  1  op-select tag of the captured result.
- `fifo_count`  out  $clog2(DEPTH)+1  commands in the FIFO, including the one in flight.
- `busy`  out  1  FSM not in IDLE.
- `timeout_err`  out  1  sticky; set on a timeout, cleared only by `rst`.

## Operation
- **Push:** `in_valid & in_ready` writes `{in_a, in_b, in_sub}` at the tail.
- **Pop:** the head is popped only on completion or timeout in WAIT.
- **Simultaneous push and pop:** count unchanged. When the FIFO is full, `in_ready` is 0 even if a pop occurs in the same cycle (no bypass).
- **FSM states:** IDLE, ISSUE, WAIT.
  - IDLE: if `count != 0` and `res_valid == 0` (`res_valid` is the registered value), load `core_a/core_b/core_addsub` from the head and go to ISSUE. Otherwise stay.
  - ISSUE: `core_start = 1` for exactly this cycle. Clear the timeout counter. Go to WAIT unconditionally.
  - WAIT: the counter increments every cycle.
    - If `core_done` is sampled high: load `res_sum = core_sum`, `res_cout = core_cout`, `res_sub = core_addsub`; set `res_valid = 1`; pop; go to IDLE.
    - Else if the counter reaches `TIMEOUT`: set `timeout_err`; pop (command discarded, no result); go to IDLE.
    - If `core_done` and the timeout occur in the same cycle, `done` wins.
- **Operand stability:** `core_a/b/addsub` hold their values from ISSUE until the next IDLE→ISSUE load.
- **Result handshake:** `res_valid & res_ready` clears `res_valid`. Result outputs hold their values while `res_valid & !res_ready`.
- **No arithmetic here:** sum and carry pass through from the core unmodified. Subtract semantics (two's complement, `cout` = no-borrow) belong to the core.
- **FIFO pointers:** wrap modulo `DEPTH`; `count` distinguishes full from empty.
- **Reset (asserted at any time, including mid-WAIT):**
  - FIFO flushed, FSM to IDLE, counter cleared.
  - All outputs 0: `core_a`, `core_b`, `core_addsub`, `core_start`, `res_valid`, `res_sum`, `res_cout`, `res_sub`, `fifo_count`, `busy`, `timeout_err`, `in_ready`.
  - In-flight and unconsumed results are dropped.

## Timing
- Command accepted at edge E0 into an empty FIFO, FSM in IDLE, `res_valid = 0`:
  - E1: state ISSUE; operands valid on `core_*`.
  - Cycle E1–E2: `core_start` high.
- With the core reporting `done` k cycles after `start`, `res_valid` rises at the edge that samples `core_done`. Dispatcher overhead is 2 cycles (IDLE→ISSUE, ISSUE→WAIT) plus result capture.
- Back-to-back: after a result is taken at edge Er (`res_valid` falls), the next ISSUE begins at the earliest at Er+1.
- Only one command is in flight, so `core_start` never reasserts before the previous `done` or timeout.
- `fifo_count` updates on the push/pop edge. `busy` is 1 in ISSUE and WAIT.

## Test plan
- **Add, signed positive:** N=8, push 42+15 (`in_sub = 0`), `res_ready = 1` → one `core_start` pulse; `res_sum = 57`, `res_cout = 0`, `res_sub = 0`; `fifo_count` returns to 0.
- **Subtract, negative result:** push 2−4 → `res_sum = 0xFE`, `res_cout = 0`. Then push 255+1 → `res_sum = 0x00`, `res_cout = 1`. Results arrive in push order.
- **Fill and backpressure:** `res_ready = 0`, push 5 commands back-to-back.
  - Expect `in_ready` to drop after 4 accepted; the 5th is held.
  - First result captured, then no further `core_start` while `res_valid = 1`; `fifo_count = 3` after the pop.
  - Release `res_ready`: the remaining commands complete in order; 88−22 → 66; 17−17 → 0 with `cout = 1`.
- **Timeout:** stub core with `core_done` tied to 0; push one command → `timeout_err = 1` exactly `TIMEOUT` cycles after WAIT entry; `fifo_count` = 0; `res_valid` stays 0; FSM returns to IDLE.
- **Reset mid-operation:** assert `rst` during WAIT with 3 commands queued → all outputs 0 asynchronously; after release, FIFO empty, `in_ready = 1`, and a fresh 24+64 yields 88.
- **Simultaneous push/pop:** push on the same edge the head pops (`core_done`) → `fifo_count` unchanged; both commands complete correctly.
